// File: rtl/reg_paralelo_serie_tx_pkg.sv
// Shared definitions for the parallel-to-serial transmitter:
// FSM state encoding and the bit-counter width helper.
package reg_paralelo_serie_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } tx_state_t;

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/reg_paralelo_serie_tx_contador_bits.sv
// contador_bits: loadable down-counter with zero flag.
// Decrement saturates at zero, so the count never wraps.
module contador_bits #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count;

  // Load has priority over decrement; hold at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/reg_paralelo_serie_tx.sv
// reg_paralelo_serie_tx: parallel-in / serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and sends it MSB
// first, one bit per clock, with sframe marking the frame bits.
// Optional feature macro: TX_PARITY_EN appends an even-parity bit.
//
// state     | meaning
// ST_IDLE   | ready for a word, sdata/sframe low
// ST_SHIFT  | data bits on the line, count tracks bits left
// ST_PARITY | parity bit on the line (TX_PARITY_EN only)
module reg_paralelo_serie_tx
  import reg_paralelo_serie_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdata,
  output logic             sframe,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  tx_state_t        state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic             sdata_d, sframe_d;
  logic             accept;
  logic             cnt_dec;
  logic             cnt_zero;

  assign load_ready = (state == ST_IDLE);
  assign accept     = load_valid & load_ready;
  assign busy       = (state != ST_IDLE);

  contador_bits #(
    .CW(CW)
  ) u_contador_bits (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (CNT_LAST),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state plus next values of the registered serial outputs.
  // The register rotates rather than shifts so the whole word is still
  // present when the last data bit goes out; parity is rotation-invariant.
  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    sdata_d  = 1'b0;
    sframe_d = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SHIFT;
          shreg_d  = D;
          sdata_d  = D[WIDTH-1];
          sframe_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_zero) begin
`ifdef TX_PARITY_EN
          state_d  = ST_PARITY;
          sdata_d  = ^shreg;
          sframe_d = 1'b1;
`else
          state_d  = ST_IDLE;
`endif
        end else begin
          cnt_dec  = 1'b1;
          shreg_d  = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
          sdata_d  = shreg[WIDTH-2];
          sframe_d = 1'b1;
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Shift register and registered line outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg  <= '0;
      sdata  <= 1'b0;
      sframe <= 1'b0;
    end else begin
      shreg  <= shreg_d;
      sdata  <= sdata_d;
      sframe <= sframe_d;
    end
  end

endmodule
